// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// requester 0 (ALU) and requester 1 (LSU). Each requester feeds its own small
// FIFO. A round-robin arbiter drains one head per cycle into registered
// write-port signals.
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   flush              sync; drops all queued writes and same-cycle enqueues
//   reqN_valid/ready   per-requester handshake (ready from registered count)
//   reqN_addr/data     destination register / value
//   wb_write_enable    register file write enable (0 for x0 beats)
//   wb_write_addr/data register file write address / data
//   wb_clear_addr      busy bit to clear, 0 when no write
//   wb_grant_id        source of the current wb_* beat
//   idle               both FIFOs empty and no write on the outputs

// Per-requester FIFO; one instance per writeback source.
module regfile_wb_arbiter_fifo #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  ready,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_mem [QDEPTH];
    logic [DATA_WIDTH-1:0] data_mem [QDEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    assign ready     = (count != CW'(QDEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Storage carries no reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wb_write_enable,
    output logic [ADDR_WIDTH-1:0] wb_write_addr,
    output logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [ADDR_WIDTH-1:0] wb_clear_addr,
    output logic                  wb_grant_id,
    output logic                  idle
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    logic    [1:0] valid, ready, empty, pop;
    wb_req_t [1:0] req, head;
    logic          rr, grant, any, contested;
    wb_req_t       sel;

    assign valid = {req1_valid, req0_valid};
    assign req   = {wb_req_t'{req1_addr, req1_data}, wb_req_t'{req0_addr, req0_data}};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        regfile_wb_arbiter_fifo #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .QDEPTH    (QDEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .push     (valid[g] && ready[g]),
            .push_addr(req[g].addr),
            .push_data(req[g].data),
            .pop      (pop[g]),
            .ready    (ready[g]),
            .empty    (empty[g]),
            .head_addr(head[g].addr),
            .head_data(head[g].data)
        );
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // rr only decides when both heads compete; otherwise the lone one wins.
    assign any       = !(empty[0] && empty[1]);
    assign contested = !empty[0] && !empty[1];
    assign grant     = contested ? rr : empty[0];
    assign sel       = head[grant];
    assign pop[0]    = any && !grant && !flush;
    assign pop[1]    = any &&  grant && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr              <= 1'b0;
            wb_write_enable <= 1'b0;
            wb_write_addr   <= '0;
            wb_write_data   <= '0;
            wb_clear_addr   <= '0;
            wb_grant_id     <= 1'b0;
        end else if (flush || !any) begin
            if (flush) rr <= 1'b0;
            wb_write_enable <= 1'b0;
            wb_write_addr   <= '0;
            wb_write_data   <= '0;
            wb_clear_addr   <= '0;
            wb_grant_id     <= 1'b0;
        end else begin
            if (contested) rr <= ~rr;
            // x0 writes still burn the slot but never touch the file.
            wb_write_enable <= (sel.addr != '0);
            wb_write_addr   <= sel.addr;
            wb_write_data   <= sel.data;
            wb_clear_addr   <= sel.addr;
            wb_grant_id     <= grant;
        end
    end

    assign idle = empty[0] && empty[1] && !wb_write_enable;
endmodule
